// File: rtl/axis_link_credit_scheduler_if.sv
// ---------------------------------------------------------------------------
// axis_link_credit_scheduler_if
// Groups the per-channel flit inputs, the shared output link and the credit
// return / status signals of the credit scheduler into one bundle.
//   ch_valid_i / ch_ready_o / ch_data_i : per-channel upstream flit handshake
//   out_valid_o / out_ready_i           : shared link handshake
//   out_data_o / out_idx_o              : link payload and granted channel
//   credit_ret_i                        : one-cycle credit return pulses
//   credit_cnt_o / err_o                : credit counters, sticky overflow
// Modport "slave" is the scheduler's view, "master" is the environment's view.
// ---------------------------------------------------------------------------
interface axis_link_credit_scheduler_if #(
    parameter int NumChannels = 2,
    parameter int DataWidth   = 64,
    parameter int NumCredits  = 8
);
    localparam int CW = $clog2(NumCredits + 1);
    localparam int IW = $clog2(NumChannels);

    logic [NumChannels-1:0]                ch_valid_i;
    logic [NumChannels-1:0]                ch_ready_o;
    logic [NumChannels-1:0][DataWidth-1:0] ch_data_i;
    logic                                  out_valid_o;
    logic                                  out_ready_i;
    logic [DataWidth-1:0]                  out_data_o;
    logic [IW-1:0]                         out_idx_o;
    logic [NumChannels-1:0]                credit_ret_i;
    logic [NumChannels-1:0][CW-1:0]        credit_cnt_o;
    logic                                  err_o;

    modport slave (
        input  ch_valid_i, ch_data_i, out_ready_i, credit_ret_i,
        output ch_ready_o, out_valid_o, out_data_o, out_idx_o, credit_cnt_o, err_o
    );

    modport master (
        output ch_valid_i, ch_data_i, out_ready_i, credit_ret_i,
        input  ch_ready_o, out_valid_o, out_data_o, out_idx_o, credit_cnt_o, err_o
    );
endinterface

// File: rtl/axis_link_credit_scheduler.sv
// ---------------------------------------------------------------------------
// axis_link_credit_scheduler
// Round-robin, credit-gated scheduler that multiplexes NumChannels flit
// channels onto one link. A channel is granted for up to BurstLen beats; each
// beat consumes one credit of that channel, credits come back via
// credit_ret_i pulses. One idle arbitration cycle separates grants.
// Ports:
//   clk_i : clock, rising edge
//   rst_i : asynchronous active-high reset
//   bus   : axis_link_credit_scheduler_if.slave (flit channels, link,
//           credit returns, credit counters, sticky overflow error)
// ---------------------------------------------------------------------------
module axis_link_credit_scheduler #(
    parameter int NumChannels = 2,
    parameter int DataWidth   = 64,
    parameter int NumCredits  = 8,
    parameter int BurstLen    = 4
) (
    input logic                          clk_i,
    input logic                          rst_i,
    axis_link_credit_scheduler_if.slave  bus
);
    localparam int CW = $clog2(NumCredits + 1);
    localparam int IW = $clog2(NumChannels);
    localparam int BW = $clog2(BurstLen + 1);

    typedef enum logic {
        IDLE,
        GRANT
    } state_e;

    state_e                         state_q, state_d;
    logic [IW-1:0]                  rrPtr_q, rrPtr_d;
    logic [IW-1:0]                  gntIdx_q, gntIdx_d;
    logic [BW-1:0]                  beatCnt_q, beatCnt_d;
    logic [NumChannels-1:0][CW-1:0] credit_q, credit_d;
    logic                           err_q, err_d;

    logic [NumChannels-1:0] eligible;
    logic                   pickFound;
    logic [IW-1:0]          pickIdx;
    int                     cand;
    logic                   gntCredOk;
    logic                   outValid;
    logic [NumChannels-1:0] chReady;
    logic                   beat;

    // Round-robin pick: first channel with valid data and a credit, scanning
    // upward from rrPtr_q and wrapping at NumChannels.
    always_comb begin
        pickFound = 1'b0;
        pickIdx   = '0;
        cand      = 0;
        for (int i = 0; i < NumChannels; i++) begin
            eligible[i] = bus.ch_valid_i[i] && (credit_q[i] != '0);
        end
        for (int k = 0; k < NumChannels; k++) begin
            cand = int'(rrPtr_q) + k;
            if (cand >= NumChannels) begin
                cand = cand - NumChannels;
            end
            if (!pickFound && eligible[cand]) begin
                pickFound = 1'b1;
                pickIdx   = IW'(cand);
            end
        end
    end

    // Grant FSM. The grant ends after the beat that completes the burst or
    // empties the credit, or on a cycle where the granted channel has no data.
    // Credit exhaustion is predicted from credit_q/credit_ret_i directly so
    // this block does not depend on the credit update logic.
    always_comb begin
        state_d   = state_q;
        rrPtr_d   = rrPtr_q;
        gntIdx_d  = gntIdx_q;
        beatCnt_d = beatCnt_q;
        outValid  = 1'b0;
        chReady   = '0;
        beat      = 1'b0;
        gntCredOk = credit_q[gntIdx_q] != '0;
        case (state_q)
            IDLE: begin
                if (pickFound) begin
                    gntIdx_d  = pickIdx;
                    beatCnt_d = '0;
                    state_d   = GRANT;
                end
            end
            GRANT: begin
                outValid          = bus.ch_valid_i[gntIdx_q] && gntCredOk;
                chReady[gntIdx_q] = bus.out_ready_i && gntCredOk;
                beat              = outValid && bus.out_ready_i;
                if (beat) begin
                    beatCnt_d = beatCnt_q + BW'(1);
                    if ((beatCnt_d == BW'(BurstLen)) ||
                        ((credit_q[gntIdx_q] == CW'(1)) && !bus.credit_ret_i[gntIdx_q])) begin
                        state_d = IDLE;
                    end
                end else if (!bus.ch_valid_i[gntIdx_q] || !gntCredOk) begin
                    state_d = IDLE;
                end
                if (state_d == IDLE) begin
                    rrPtr_d = (gntIdx_q == IW'(NumChannels - 1)) ? '0 : gntIdx_q + IW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Credit counters: a return and a beat in the same cycle cancel out; a
    // return onto a full counter saturates and raises the sticky error.
    always_comb begin
        credit_d = credit_q;
        err_d    = err_q;
        for (int i = 0; i < NumChannels; i++) begin
            if (bus.credit_ret_i[i] && !(beat && (gntIdx_q == IW'(i)))) begin
                if (credit_q[i] == CW'(NumCredits)) begin
                    err_d = 1'b1;
                end else begin
                    credit_d[i] = credit_q[i] + CW'(1);
                end
            end else if (!bus.credit_ret_i[i] && beat && (gntIdx_q == IW'(i))) begin
                credit_d[i] = credit_q[i] - CW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            rrPtr_q   <= '0;
            gntIdx_q  <= '0;
            beatCnt_q <= '0;
            err_q     <= 1'b0;
            for (int i = 0; i < NumChannels; i++) begin
                credit_q[i] <= CW'(NumCredits);
            end
        end else begin
            state_q   <= state_d;
            rrPtr_q   <= rrPtr_d;
            gntIdx_q  <= gntIdx_d;
            beatCnt_q <= beatCnt_d;
            err_q     <= err_d;
            credit_q  <= credit_d;
        end
    end

    assign bus.out_valid_o  = outValid;
    assign bus.ch_ready_o   = chReady;
    assign bus.out_data_o   = bus.ch_data_i[gntIdx_q];
    assign bus.out_idx_o    = gntIdx_q;
    assign bus.credit_cnt_o = credit_q;
    assign bus.err_o        = err_q;
endmodule

// File: tb/tb_axis_link_credit_scheduler.sv
// ---------------------------------------------------------------------------
// tb_axis_link_credit_scheduler
// Bench for the credit scheduler with two channels, 8 credits, bursts of 4.
// Upstream channels behave like FIFOs: each channel presents a payload tagged
// with its index and a per-channel sequence number that advances on every
// accepted beat. Expected link beats are queued up front and matched against
// the link in order; a vector table covers the per-cycle corner cases.
// ---------------------------------------------------------------------------
module tb_axis_link_credit_scheduler;
    localparam int NumChannels = 2;
    localparam int DataWidth   = 64;
    localparam int NumCredits  = 8;
    localparam int BurstLen    = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    axis_link_credit_scheduler_if #(
        .NumChannels(NumChannels),
        .DataWidth  (DataWidth),
        .NumCredits (NumCredits)
    ) bus ();

    axis_link_credit_scheduler #(
        .NumChannels(NumChannels),
        .DataWidth  (DataWidth),
        .NumCredits (NumCredits),
        .BurstLen   (BurstLen)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    typedef struct {
        logic [63:0] data;
        logic        idx;
    } beat_t;

    typedef struct {
        logic [1:0] valid;
        logic       ready;
        logic [1:0] ret;
        logic       expValid;
        logic       expIdx;
        logic [1:0] expReady;
        int         expCr0;
        int         expCr1;
        logic       expErr;
    } vec_t;

    beat_t       sb[$];
    vec_t        vecs[15];
    int          vectors    = 0;
    int          miscompares = 0;
    int          seq[NumChannels];
    logic [1:0]  lastHs;
    logic        prevStall;
    logic [63:0] prevData;
    logic        prevIdx;

    // Payload presented by channel ch for its s-th flit.
    function automatic logic [63:0] mkData(input int ch, input int s);
        return {32'hC0DE0000 | 32'(ch), 32'(s)};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic driveData();
        for (int i = 0; i < NumChannels; i++) begin
            bus.ch_data_i[i] = mkData(i, seq[i]);
        end
    endtask

    task automatic pushBeat(input int ch, input int s);
        beat_t b;
        b.data = mkData(ch, s);
        b.idx  = 1'(ch);
        sb.push_back(b);
    endtask

    // Samples the link at the falling edge: matches accepted beats against
    // the queue and verifies that a stalled beat is held unchanged.
    task automatic sampleEdge();
        beat_t b;
        @(negedge clk);
        lastHs = bus.ch_valid_i & bus.ch_ready_o;
        if (!rst) begin
            if (prevStall) begin
                check("stall_hold_valid", 64'(bus.out_valid_o), 64'd1);
                check("stall_hold_data", bus.out_data_o, prevData);
                check("stall_hold_idx", 64'(bus.out_idx_o), 64'(prevIdx));
            end
            if (bus.out_valid_o && bus.out_ready_i) begin
                if (sb.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("[TB] FAIL sb_unexpected_beat: got data %0h idx %0d, expected no beat",
                             bus.out_data_o, bus.out_idx_o);
                end else begin
                    b = sb.pop_front();
                    check("sb_data", bus.out_data_o, b.data);
                    check("sb_idx", 64'(bus.out_idx_o), 64'(b.idx));
                end
            end
            prevStall = bus.out_valid_o && !bus.out_ready_i;
            prevData  = bus.out_data_o;
            prevIdx   = bus.out_idx_o;
        end else begin
            prevStall = 1'b0;
        end
    endtask

    // Moves past the rising edge and lets each upstream FIFO advance.
    task automatic advance();
        @(posedge clk);
        #1;
        for (int i = 0; i < NumChannels; i++) begin
            if (rst) seq[i] = 0;
            else if (lastHs[i]) seq[i] = seq[i] + 1;
        end
        driveData();
    endtask

    task automatic doReset();
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < NumChannels; i++) seq[i] = 0;
        sb.delete();
        prevStall = 1'b0;
        lastHs    = '0;
        driveData();
    endtask

    task automatic applyStimulus(input vec_t v);
        bus.ch_valid_i   = v.valid;
        bus.out_ready_i  = v.ready;
        bus.credit_ret_i = v.ret;
    endtask

    task automatic checkOutput(input vec_t v, input int k);
        check($sformatf("vec%0d_out_valid", k), 64'(bus.out_valid_o), 64'(v.expValid));
        if (v.expValid) begin
            check($sformatf("vec%0d_out_idx", k), 64'(bus.out_idx_o), 64'(v.expIdx));
        end
        check($sformatf("vec%0d_ch_ready", k), 64'(bus.ch_ready_o), 64'(v.expReady));
        check($sformatf("vec%0d_credit0", k), 64'(bus.credit_cnt_o[0]), 64'(v.expCr0));
        check($sformatf("vec%0d_credit1", k), 64'(bus.credit_cnt_o[1]), 64'(v.expCr1));
        check($sformatf("vec%0d_err", k), 64'(bus.err_o), 64'(v.expErr));
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int beats;
        logic expV;

        bus.ch_valid_i   = '0;
        bus.out_ready_i  = 1'b0;
        bus.credit_ret_i = '0;
        for (int i = 0; i < NumChannels; i++) seq[i] = 0;
        prevStall = 1'b0;
        prevData  = '0;
        prevIdx   = 1'b0;
        lastHs    = '0;
        driveData();

        // valid, ready, ret | expValid, expIdx, expReady, cr0, cr1, err
        vecs[0]  = '{2'b01, 1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 8, 8, 1'b0}; // IDLE bubble, ch0 picked
        vecs[1]  = '{2'b01, 1'b1, 2'b00, 1'b1, 1'b0, 2'b01, 8, 8, 1'b0}; // beat 1
        vecs[2]  = '{2'b01, 1'b0, 2'b00, 1'b1, 1'b0, 2'b00, 7, 8, 1'b0}; // stall
        vecs[3]  = '{2'b01, 1'b1, 2'b00, 1'b1, 1'b0, 2'b01, 7, 8, 1'b0}; // beat 2
        vecs[4]  = '{2'b00, 1'b1, 2'b00, 1'b0, 1'b0, 2'b01, 6, 8, 1'b0}; // ch0 drops valid
        vecs[5]  = '{2'b11, 1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 6, 8, 1'b0}; // IDLE, rr=1 picks ch1
        vecs[6]  = '{2'b11, 1'b1, 2'b00, 1'b1, 1'b1, 2'b10, 6, 8, 1'b0}; // ch1 beat 1
        vecs[7]  = '{2'b10, 1'b1, 2'b01, 1'b1, 1'b1, 2'b10, 6, 7, 1'b0}; // ch0 return during ch1 grant
        vecs[8]  = '{2'b10, 1'b1, 2'b10, 1'b1, 1'b1, 2'b10, 7, 6, 1'b0}; // return + beat cancel
        vecs[9]  = '{2'b10, 1'b1, 2'b00, 1'b1, 1'b1, 2'b10, 7, 6, 1'b0}; // beat 4 ends burst
        vecs[10] = '{2'b00, 1'b1, 2'b01, 1'b0, 1'b0, 2'b00, 7, 5, 1'b0}; // ch0 back to full
        vecs[11] = '{2'b00, 1'b1, 2'b01, 1'b0, 1'b0, 2'b00, 8, 5, 1'b0}; // overflow return
        vecs[12] = '{2'b00, 1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 8, 5, 1'b1}; // saturated, err set
        vecs[13] = '{2'b00, 1'b1, 2'b10, 1'b0, 1'b0, 2'b00, 8, 5, 1'b1}; // err sticky
        vecs[14] = '{2'b00, 1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 8, 6, 1'b1};

        // Vector table with the expected link beats queued beforehand.
        applyStimulus(vecs[0]);
        doReset();
        pushBeat(0, 0);
        pushBeat(0, 1);
        for (int s = 0; s < 4; s++) pushBeat(1, s);
        for (int k = 0; k < 15; k++) begin
            applyStimulus(vecs[k]);
            sampleEdge();
            checkOutput(vecs[k], k);
            advance();
        end
        check("table_sb_drained", 64'(sb.size()), 64'd0);

        // Both channels streaming until credits run out.
        bus.ch_valid_i   = 2'b11;
        bus.out_ready_i  = 1'b1;
        bus.credit_ret_i = 2'b00;
        doReset();
        for (int s = 0; s < 4; s++) pushBeat(0, s);
        for (int s = 0; s < 4; s++) pushBeat(1, s);
        for (int s = 4; s < 8; s++) pushBeat(0, s);
        for (int s = 4; s < 8; s++) pushBeat(1, s);
        pushBeat(0, 8);
        pushBeat(0, 9);
        for (int c = 0; c < 24; c++) begin
            sampleEdge();
            if (c == 0) begin
                check("reset_ch_ready", 64'(bus.ch_ready_o), 64'd0);
                check("reset_credit0", 64'(bus.credit_cnt_o[0]), 64'd8);
                check("reset_credit1", 64'(bus.credit_cnt_o[1]), 64'd8);
                check("reset_err", 64'(bus.err_o), 64'd0);
            end
            expV = (c >= 1 && c <= 4) || (c >= 6 && c <= 9) ||
                   (c >= 11 && c <= 14) || (c >= 16 && c <= 19);
            check($sformatf("burst_valid_c%0d", c), 64'(bus.out_valid_o), 64'(expV));
            advance();
        end
        // Both channels exhausted; return one credit to ch0 and overlap a
        // second return with the beat it enables.
        bus.credit_ret_i = 2'b01;
        sampleEdge();
        check("exhaust_credit0", 64'(bus.credit_cnt_o[0]), 64'd0);
        check("exhaust_credit1", 64'(bus.credit_cnt_o[1]), 64'd0);
        check("exhaust_valid", 64'(bus.out_valid_o), 64'd0);
        advance();
        bus.credit_ret_i = 2'b00;
        sampleEdge();
        check("one_credit_bubble", 64'(bus.out_valid_o), 64'd0);
        advance();
        bus.credit_ret_i = 2'b01;
        sampleEdge();
        check("one_credit_valid", 64'(bus.out_valid_o), 64'd1);
        check("one_credit_idx", 64'(bus.out_idx_o), 64'd0);
        advance();
        bus.credit_ret_i = 2'b00;
        sampleEdge();
        check("overlap_credit0", 64'(bus.credit_cnt_o[0]), 64'd1);
        check("overlap_err", 64'(bus.err_o), 64'd0);
        check("overlap_valid", 64'(bus.out_valid_o), 64'd1);
        advance();
        sampleEdge();
        check("drained_credit0", 64'(bus.credit_cnt_o[0]), 64'd0);
        check("drained_valid", 64'(bus.out_valid_o), 64'd0);
        check("burst_sb_drained", 64'(sb.size()), 64'd0);
        advance();

        // Channel 1 alone with link ready toggling every cycle.
        bus.ch_valid_i  = 2'b10;
        bus.out_ready_i = 1'b0;
        doReset();
        for (int s = 0; s < 8; s++) pushBeat(1, s);
        beats = 0;
        for (int c = 0; c < 60 && beats < 8; c++) begin
            bus.out_ready_i = (c % 2 == 0);
            sampleEdge();
            check("toggle_credit1", 64'(bus.credit_cnt_o[1]), 64'(NumCredits - beats));
            if (lastHs[1]) beats++;
            advance();
        end
        check("toggle_beats", 64'(beats), 64'd8);
        bus.out_ready_i = 1'b1;
        sampleEdge();
        check("toggle_final_credit1", 64'(bus.credit_cnt_o[1]), 64'd0);
        check("toggle_final_valid", 64'(bus.out_valid_o), 64'd0);
        check("toggle_sb_drained", 64'(sb.size()), 64'd0);
        advance();

        // Reset in the middle of a channel-1 burst.
        bus.ch_valid_i  = 2'b11;
        bus.out_ready_i = 1'b1;
        doReset();
        for (int s = 0; s < 4; s++) pushBeat(0, s);
        pushBeat(1, 0);
        pushBeat(1, 1);
        for (int c = 0; c < 8; c++) begin
            sampleEdge();
            advance();
        end
        rst = 1'b1;
        #1;
        check("midrst_valid", 64'(bus.out_valid_o), 64'd0);
        check("midrst_ch_ready", 64'(bus.ch_ready_o), 64'd0);
        check("midrst_credit0", 64'(bus.credit_cnt_o[0]), 64'd8);
        check("midrst_credit1", 64'(bus.credit_cnt_o[1]), 64'd8);
        check("midrst_sb_drained", 64'(sb.size()), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < NumChannels; i++) seq[i] = 0;
        prevStall = 1'b0;
        lastHs    = '0;
        driveData();
        for (int s = 0; s < 4; s++) pushBeat(0, s);
        for (int c = 0; c < 6; c++) begin
            sampleEdge();
            if (c == 1) begin
                check("postrst_valid", 64'(bus.out_valid_o), 64'd1);
                check("postrst_idx", 64'(bus.out_idx_o), 64'd0);
            end
            advance();
        end
        check("postrst_sb_drained", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/axis_link_credit_scheduler.md
AXIS_LINK_CREDIT_SCHEDULER -- requirements
Module: axis_link_credit_scheduler

Interface
REQ-001 SHALL have parameter NumChannels, default 2, number of requesting flit channels (>=2).
REQ-002 SHALL have parameter DataWidth, default 64, flit payload width.
REQ-003 SHALL have parameter NumCredits, default 8, credits per channel; counter width CW = clog2(NumCredits+1).
REQ-004 SHALL have parameter BurstLen, default 4, maximum beats per grant; beat counter width clog2(BurstLen+1).
REQ-005 SHALL have port clk_i  input  1  single clock; all logic on rising edge.
REQ-006 SHALL have port rst_i  input  1  reset, asynchronous and active-high.
REQ-007 SHALL have port ch_valid_i  input  NumChannels  per-channel valid.
REQ-008 SHALL have port ch_ready_o  output  NumChannels  per-channel ready.
REQ-009 SHALL have port ch_data_i  input  NumChannels x DataWidth  per-channel payload.
REQ-010 SHALL have port out_valid_o  output  1  link valid.
REQ-011 SHALL have port out_ready_i  input  1  link ready.
REQ-012 SHALL have port out_data_o  output  DataWidth  payload of the granted channel.
REQ-013 SHALL have port out_idx_o  output  clog2(NumChannels)  granted channel index (link header).
REQ-014 SHALL have port credit_ret_i  input  NumChannels  one-cycle pulse, returns one credit to channel i.
REQ-015 SHALL have port credit_cnt_o  output  NumChannels x CW  current credit count per channel.
REQ-016 SHALL have port err_o  output  1  sticky credit-overflow flag.

Function
REQ-017 SHALL implement FSM with states IDLE and GRANT.
REQ-018 SHALL define channel i eligible when ch_valid_i[i]=1 and credit[i]>0.
REQ-019 In IDLE, SHALL select the first eligible channel at or after rr_ptr (modulo NumChannels), register it as gnt_idx, clear beat counter, and enter GRANT next cycle; with none eligible, stay in IDLE.
REQ-020 In IDLE, SHALL drive out_valid_o=0 and ch_ready_o=0 (one-cycle arbitration bubble).
REQ-021 In GRANT, SHALL drive out_valid_o = ch_valid_i[gnt_idx] & (credit[gnt_idx]>0), out_data_o = ch_data_i[gnt_idx], out_idx_o = gnt_idx, and ch_ready_o[gnt_idx] = out_ready_i & (credit[gnt_idx]>0); all other ch_ready_o bits 0.
REQ-022 A beat SHALL be transferred when out_valid_o & out_ready_i; each beat increments the beat counter and decrements credit[gnt_idx].
REQ-023 GRANT SHALL return to IDLE, with rr_ptr = gnt_idx+1 (wrapping to 0 after NumChannels-1), on the cycle after: beat counter reaches BurstLen, credit[gnt_idx] reaches 0, or ch_valid_i[gnt_idx]=0 with no transfer.
REQ-024 SHALL never drop out_valid_o or change out_data_o/out_idx_o while out_valid_o=1 and out_ready_i=0 (provided the upstream channel holds valid/data).
REQ-025 credit[i] SHALL update per cycle: +1 on credit_ret_i[i], -1 on a beat from i, unchanged when both occur together.
REQ-026 A return that would exceed NumCredits SHALL saturate credit[i] at NumCredits and set err_o, which stays 1 until reset.
REQ-027 Channel with credit 0 SHALL not be granted; a credit returned while in GRANT on another channel SHALL be visible at the next IDLE arbitration.
REQ-028 Throughput SHALL be one beat per cycle inside a grant; out_valid_o SHALL be combinational from ch_valid_i in GRANT (zero-cycle forward latency).

Reset
REQ-029 On rst_i=1, asynchronously: state=IDLE, rr_ptr=0, gnt_idx=0, beat counter=0, every credit[i]=NumCredits, err_o=0; hence out_valid_o=0, ch_ready_o=0, out_idx_o=0.
REQ-030 Reset asserted mid-burst SHALL abort the grant with no further beats and restore full credits.

Verification
REQ-031 Both channels valid continuously, out_ready_i=1, NumCredits=8, BurstLen=4 -> 4 beats idx 0, bubble, 4 beats idx 1, bubble; channel 0 then credit 4, repeat until both at 0, then out_valid_o stays 0.
REQ-032 Channel 1 only valid, out_ready_i toggling 1/0 -> out_data_o/out_idx_o stable during each stall, credit_cnt_o[1] decrements only on handshakes.
REQ-033 Channel 0 credit 0, credit_ret_i[0] pulse same cycle as a beat from channel 0 at credit 1 -> credit stays 1, no error.
REQ-034 credit_ret_i[0] pulsed with credit[0]=8 -> credit stays 8, err_o=1 and remains 1 until rst_i.
REQ-035 Channel 0 drops valid after 2 beats of a 4-beat grant -> return to IDLE, rr_ptr=1, channel 1 granted next if valid.
REQ-036 rst_i asserted in GRANT mid-burst -> out_valid_o=0 immediately, all credit_cnt_o=8, first grant after release goes to channel 0.
